// File: rtl/l1c_arb_pkg.sv
// Shared types and constants for the L1 I/D-cache memory-port arbiter.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
`ifndef CACHE_TYPE_BITS
`define CACHE_TYPE_BITS 3
`endif

package l1c_arb_pkg;

  // Arbiter ownership states: nobody, I-cache, or D-cache holds the port.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_I = 2'd1,
    ARB_OWN_D = 2'd2
  } arb_state_e;

  // Default burst lengths: a line fill is 4 read beats, a write-through is 1 beat.
  localparam int LINE_BEATS_DEF = 4;
  localparam int WR_BEATS_DEF   = 1;

  // Bit positions of the two requesters in the round-robin request/grant vectors.
  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  // Encoding of the last-granted requester register.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/l1c_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick. A lone requester always wins;
// on a tie the requester that was not granted last time wins.
module rr_pick2
  import l1c_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Pick a single winner (one-hot) or nobody when neither side requests.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == LAST_D) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/l1c_mem_arbiter.sv
// Shares the single CPU-wrapper memory port between the L1 I-cache and
// L1 D-cache. The grant is registered, held for a whole line fill or one
// write-through beat, and always returns through IDLE so the other side
// gets the next turn. The request itself is never latched: while a side
// owns the port its signals are forwarded combinationally.
module l1c_mem_arbiter
  import l1c_arb_pkg::*;
#(
  parameter int LINE_BEATS = LINE_BEATS_DEF,
  parameter int WR_BEATS   = WR_BEATS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        I_req,
  input  logic [`DATA_BITS-1:0]       I_addr,
  input  logic                        I_write,
  input  logic [`DATA_BITS-1:0]       I_in,
  input  logic [`CACHE_TYPE_BITS-1:0] I_type,
  output logic                        I_wait,
  output logic [`DATA_BITS-1:0]       I_out,

  input  logic                        D_req,
  input  logic [`DATA_BITS-1:0]       D_addr,
  input  logic                        D_write,
  input  logic [`DATA_BITS-1:0]       D_in,
  input  logic [`CACHE_TYPE_BITS-1:0] D_type,
  output logic                        D_wait,
  output logic [`DATA_BITS-1:0]       D_out,

  output logic                        M_req,
  output logic [`DATA_BITS-1:0]       M_addr,
  output logic                        M_write,
  output logic [`DATA_BITS-1:0]       M_in,
  output logic [`CACHE_TYPE_BITS-1:0] M_type,
  input  logic                        M_wait,
  input  logic [`DATA_BITS-1:0]       M_out
);

  // The beat counter must be able to hold LINE_BEATS itself so it can saturate.
  localparam int CNT_BITS = $clog2(LINE_BEATS + 1);
  localparam logic [CNT_BITS-1:0] LAST_RD_BEAT = CNT_BITS'(LINE_BEATS - 1);
  localparam logic [CNT_BITS-1:0] LAST_WR_BEAT = CNT_BITS'(WR_BEATS - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX      = CNT_BITS'(LINE_BEATS);

  arb_state_e          state;
  logic [CNT_BITS-1:0] beat_cnt;
  logic                last_grant;

  logic [1:0]          gnt;
  logic                own_i;
  logic                own_d;
  logic                owned;
  logic                sel_req;
  logic                sel_write;
  logic                beat_done;
  logic                last_beat;
  logic                release_grant;

  // Round-robin choice made while IDLE; bit REQ_I is the I-cache, REQ_D the D-cache.
  rr_pick2 u_pick (
    .req  ({D_req, I_req}),
    .last (last_grant),
    .gnt  (gnt)
  );

  // Ownership is qualified by reset so the port is let go the instant reset asserts.
  assign own_i = rst && (state == ARB_OWN_I);
  assign own_d = rst && (state == ARB_OWN_D);
  assign owned = own_i || own_d;

  // Beat-completion and release decisions for whichever side currently owns the port.
  always_comb begin
    sel_req   = 1'b0;
    sel_write = 1'b0;
    if (own_i) begin
      sel_req   = I_req;
      sel_write = I_write;
    end else if (own_d) begin
      sel_req   = D_req;
      sel_write = D_write;
    end
    beat_done     = owned && sel_req && !M_wait;
    last_beat     = sel_write ? (beat_cnt == LAST_WR_BEAT) : (beat_cnt == LAST_RD_BEAT);
    release_grant = owned && (!sel_req || (beat_done && last_beat));
  end

  // Arbitration FSM with the beat counter and last-grant memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      beat_cnt   <= '0;
      last_grant <= LAST_D;
    end else begin
      case (state)
        ARB_IDLE: begin
          beat_cnt <= '0;
          if (gnt[REQ_I]) begin
            state <= ARB_OWN_I;
          end else if (gnt[REQ_D]) begin
            state <= ARB_OWN_D;
          end
        end
        ARB_OWN_I,
        ARB_OWN_D: begin
          if (release_grant) begin
            state      <= ARB_IDLE;
            beat_cnt   <= '0;
            last_grant <= (state == ARB_OWN_I) ? LAST_I : LAST_D;
          end else if (beat_done && (beat_cnt != CNT_MAX)) begin
            beat_cnt <= beat_cnt + CNT_BITS'(1);
          end
        end
        default: begin
          state    <= ARB_IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Output mux: the owner sees the wrapper directly, the other side just stalls.
  always_comb begin
    M_req   = 1'b0;
    M_addr  = '0;
    M_write = 1'b0;
    M_in    = '0;
    M_type  = '0;
    I_wait  = I_req;
    D_wait  = D_req;
    I_out   = '0;
    D_out   = '0;
    if (own_i) begin
      M_req   = I_req;
      M_addr  = I_addr;
      M_write = I_write;
      M_in    = I_in;
      M_type  = I_type;
      I_wait  = M_wait;
      I_out   = M_out;
    end else if (own_d) begin
      M_req   = D_req;
      M_addr  = D_addr;
      M_write = D_write;
      M_in    = D_in;
      M_type  = D_type;
      D_wait  = M_wait;
      D_out   = M_out;
    end
  end

endmodule
